// File: rtl/immediate_encoder_if.sv
// Handshake and result bundle for immediate_encoder.
// master: producer/consumer side; slave: the encoder itself.
interface immediate_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic        out_valid;
  logic        out_ready;
  logic        encodable;
  logic [11:0] immediate;
  logic        check_err;

  modport master (
    output in_valid, value, out_ready,
    input  in_ready, out_valid, encodable, immediate, check_err
  );

  modport slave (
    input  in_valid, value, out_ready,
    output in_ready, out_valid, encodable, immediate, check_err
  );
endinterface

// File: rtl/immediate_encoder.sv
// immediate_encoder: finds the lowest rot (0..15) such that a 32-bit constant
// equals ROR({24'b0,imm8}, 2*rot), one rot candidate per clock cycle.
// Result is {rot, imm8}; non-encodable constants report encodable=0, 12'h000.
// Optional macro IMMEDIATE_ENCODER_SELFCHECK_EN: re-expands the result on
// entry to DONE and flags check_err when it does not reproduce the constant.
module immediate_encoder (
  input logic                 clk,
  input logic                 rst,
  immediate_encoder_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_val;
  logic [3:0]  r_rot;
  logic        r_enc;
  logic [11:0] r_imm;

  logic [4:0]  w_shamt;
  logic [31:0] w_cand;
  logic        w_match;
  logic        w_last;

  // Candidate for the current rot: ROL(val_q, 2*rot); shamt 0 makes the
  // right-shift term a full-width shift, which yields zero.
  always_comb begin
    w_shamt = {r_rot, 1'b0};
    w_cand  = (r_val << w_shamt) | (r_val >> (6'd32 - {1'b0, w_shamt}));
    w_match = (w_cand[31:8] == 24'h000000);
    w_last  = (r_rot == 4'd15);
  end

  // Handshake, search sequencing and result latching
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_val   <= '0;
      r_rot   <= '0;
      r_enc   <= 1'b0;
      r_imm   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_val   <= bus.value;
            r_rot   <= '0;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_match) begin
            r_enc   <= 1'b1;
            r_imm   <= {r_rot, w_cand[7:0]};
            r_state <= S_DONE;
          end else if (w_last) begin
            r_enc   <= 1'b0;
            r_imm   <= '0;
            r_state <= S_DONE;
          end else begin
            r_rot   <= r_rot + 4'd1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.encodable = r_enc;
  assign bus.immediate = r_imm;

`ifdef IMMEDIATE_ENCODER_SELFCHECK_EN
  logic        r_chk;
  logic [31:0] w_imm_ext;
  logic [31:0] w_recon;

  // Re-expand the result being latched: ROR({24'b0,imm8}, 2*rot)
  always_comb begin
    w_imm_ext = {24'h000000, w_cand[7:0]};
    w_recon   = (w_imm_ext >> w_shamt) | (w_imm_ext << (6'd32 - {1'b0, w_shamt}));
  end

  // Check flag is evaluated on the same edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk <= 1'b0;
    end else if (r_state == S_SEARCH) begin
      if (w_match) begin
        r_chk <= (w_recon != r_val);
      end else if (w_last) begin
        r_chk <= 1'b0;
      end
    end
  end

  assign bus.check_err = r_chk;
`else
  assign bus.check_err = 1'b0;
`endif

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed and randomized checks for immediate_encoder with a brute-force
// reference built directly from the ROR({24'b0,imm8},2*rot) definition.
module tb_immediate_encoder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  immediate_encoder_if bus ();

  immediate_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rol_bits(input logic [31:0] x, input int s);
    logic [31:0] t;
    t = x;
    for (int i = 0; i < s; i++) t = {t[30:0], t[31]};
    return t;
  endfunction

  function automatic logic [31:0] ror_bits(input logic [31:0] x, input int s);
    logic [31:0] t;
    t = x;
    for (int i = 0; i < s; i++) t = {t[0], t[31:1]};
    return t;
  endfunction

  // Lowest rot wins: scan downwards so the last hit is the smallest rot.
  function automatic void model(input logic [31:0] v, output logic e,
                                output logic [11:0] im, output int lat);
    logic [31:0] c;
    logic [3:0]  rr;
    e   = 1'b0;
    im  = '0;
    lat = 16;
    for (int r = 15; r >= 0; r--) begin
      c  = rol_bits(v, 2 * r);
      rr = r[3:0];
      if (ror_bits({24'h000000, c[7:0]}, 2 * r) == v) begin
        e   = 1'b1;
        im  = {rr, c[7:0]};
        lat = r + 1;
      end
    end
  endfunction

  task automatic run_op(input logic [31:0] v, input logic enc_e,
                        input logic [11:0] imm_e, input int lat_e, input string tag);
    int n;
    chk({tag, " in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.value    = v;
    step;
    bus.in_valid = 1'b0;
    bus.value    = $urandom;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step;
      n++;
    end
    chk({tag, " latency"},   32'(n),             32'(lat_e));
    chk({tag, " encodable"}, 32'(bus.encodable), 32'(enc_e));
    chk({tag, " immediate"}, 32'(bus.immediate), 32'(imm_e));
    chk({tag, " check_err"}, 32'(bus.check_err), 32'd0);
    if (bus.encodable)
      chk({tag, " reexpand"}, ror_bits({24'h000000, bus.immediate[7:0]},
                                       2 * int'(bus.immediate[11:8])), v);
    bus.out_ready = 1'b1;
    step;
    bus.out_ready = 1'b0;
    chk({tag, " in_ready_post"},  32'(bus.in_ready),  32'd1);
    chk({tag, " out_valid_post"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic        e;
    logic [11:0] im;
    int          lat;
    int          n;
    logic        seen;

    n_tests = 0;
    n_fail  = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.value     = '0;
    bus.out_ready = 1'b0;
    step;
    step;
    rst = 1'b0;

    chk("rst in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst encodable", 32'(bus.encodable), 32'd0);
    chk("rst immediate", 32'(bus.immediate), 32'd0);
    chk("rst check_err", 32'(bus.check_err), 32'd0);

    run_op(32'h000000FF, 1'b1, 12'h0FF, 1,  "v_000000FF");
    run_op(32'hFF000000, 1'b1, 12'h4FF, 5,  "v_FF000000");
    run_op(32'hF000000F, 1'b1, 12'h2FF, 3,  "v_F000000F");
    run_op(32'h00000102, 1'b0, 12'h000, 16, "v_00000102");
    run_op(32'h00000000, 1'b1, 12'h000, 1,  "v_00000000");
    run_op(32'h000003FC, 1'b1, 12'hFFF, 16, "v_000003FC");
    run_op(32'hC000003F, 1'b1, 12'h1FF, 2,  "v_C000003F");
    run_op(32'h00000100, 1'b1, 12'hC01, 13, "v_00000100");
    run_op(32'h80000001, 1'b1, 12'h106, 2,  "v_80000001");

    // Hold result under backpressure while new offers are ignored
    bus.in_valid = 1'b1;
    bus.value    = 32'hFF000000;
    step;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step;
      n++;
    end
    chk("hold latency", 32'(n), 32'd5);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.value    = 32'h000000FF;
      step;
      chk("hold immediate", 32'(bus.immediate), 32'h4FF);
      chk("hold encodable", 32'(bus.encodable), 32'd1);
      chk("hold out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    step;
    bus.out_ready = 1'b0;
    chk("release in_ready",  32'(bus.in_ready),  32'd1);
    chk("release out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    step;
    chk("no reaccept in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a search
    bus.in_valid = 1'b1;
    bus.value    = 32'h00000102;
    step;
    bus.in_valid = 1'b0;
    repeat (7) step;
    chk("midsearch out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst encodable", 32'(bus.encodable), 32'd0);
    chk("midrst immediate", 32'(bus.immediate), 32'd0);
    chk("midrst check_err", 32'(bus.check_err), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      seen = seen | bus.out_valid;
    end
    chk("midrst no out_valid", 32'(seen), 32'd0);
    run_op(32'h00000000, 1'b1, 12'h000, 1, "post_rst_zero");

    // Random constants: half arbitrary, half built from a known encoding
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        v = $urandom;
      end else begin
        v = ror_bits({24'h000000, 8'($urandom_range(0, 255))},
                     2 * int'($urandom_range(0, 15)));
      end
      model(v, e, im, lat);
      run_op(v, e, im, lat, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/immediate_encoder.md
IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  a 32-bit constant is offered on value.
REQ-005 in_ready  output  1  block can accept a new value.
REQ-006 value  input  32  constant to encode; sampled only on the accept edge.
REQ-007 out_valid  output  1  result is valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 encodable  output  1  1 when value = ROR({24'b0,imm8}, 2*rot) for some rot in 0..15.
REQ-010 immediate  output  12  {rot[3:0], imm8[7:0]}, in the format consumed by immediate_extender.
REQ-011 check_err  output  1  self-check mismatch; behaviour per REQ-027/028.

Function
REQ-012 FSM states SHALL be IDLE, SEARCH and DONE; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-013 Accept: in_valid && in_ready at an edge SHALL capture value into val_q, clear rot to 0, and enter SEARCH.
REQ-014 SEARCH: each cycle SHALL form cand = ROL(val_q, 2*rot), 32-bit rotate with wrap-around, and rot=0 giving cand = val_q.
REQ-015 SEARCH: if cand[31:8]==0, the next edge SHALL latch encodable=1 and immediate={rot, cand[7:0]}, then enter DONE.
REQ-016 SEARCH: if there is no match and rot==15, the next edge SHALL latch encodable=0 and immediate=12'h000, then enter DONE.
REQ-017 SEARCH: if there is no match and rot<15, rot SHALL increment by 1 and the FSM SHALL stay in SEARCH.
REQ-018 Lowest matching rot SHALL win; value 0 SHALL yield rot=0, imm8=0.
REQ-019 Latency: when the first match is at rot=k, out_valid SHALL rise in the cycle after the (k+1)th edge following acceptance (1..16); a non-encodable value SHALL take 16.
REQ-020 DONE: encodable, immediate and check_err SHALL hold stable while out_ready=0, for any number of cycles.
REQ-021 DONE with out_ready=1 at an edge SHALL return the FSM to IDLE; in_ready SHALL be high the next cycle, with no same-edge re-accept.
REQ-022 in_valid in SEARCH or DONE SHALL be ignored; value changes after acceptance SHALL NOT affect the result.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, rot=0, val_q=0, encodable=0, immediate=0, check_err=0.
REQ-024 After reset: in_ready=1 and out_valid=0.
REQ-025 rst SHALL take priority over every handshake; reset asserted in SEARCH or DONE SHALL discard the operation with no out_valid.
REQ-026 The first accept after reset SHALL be possible on the edge after rst deasserts.

Configuration
REQ-027 Macro IMMEDIATE_ENCODER_SELFCHECK_EN defined: on entry to DONE with encodable=1, the block SHALL recompute ROR({24'b0,imm8}, 2*rot); check_err SHALL be 1 when the result differs from val_q, 0 otherwise; check_err SHALL be 0 when encodable=0.
REQ-028 Macro IMMEDIATE_ENCODER_SELFCHECK_EN undefined: check_err SHALL be tied to 0 and no checking logic SHALL be synthesised.

Verification
REQ-029 value=32'h000000FF -> encodable=1, immediate=12'h0FF, out_valid 1 edge after accept.
REQ-030 value=32'hFF000000 -> encodable=1, immediate=12'h4FF, latency 5; value=32'hF000000F -> immediate=12'h2FF, latency 3.
REQ-031 value=32'h00000102 -> encodable=0, immediate=12'h000, latency 16.
REQ-032 Result 12'h4FF with out_ready=0 for 10 cycles -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulsed at rot=7 while searching 32'h00000102 -> IDLE, all outputs 0, no out_valid; next value 32'h00000000 -> immediate=12'h000, encodable=1, latency 1.
REQ-034 With IMMEDIATE_ENCODER_SELFCHECK_EN, random values (10k) -> check_err=0 always, and each encodable result fed to immediate_extender reproduces value.
